arbiter2x1_8bits: RTL



---
 rtl/arbiter2x1_8bits.sv | 129 ++++++++++++
 1 files changed

// File: rtl/arbiter2x1_8bits.sv
// arbiter2x1_8bits: round-robin merge of two lane FIFOs into one registered data/valid stream.
// Build option IDLE_FILL_EN: data_out carries IDLE_SYM whenever valid_out is low.
module arbiter2x1_8bits #(
  parameter int unsigned INIT_CYCLES = 4,
  parameter logic [7:0]  IDLE_SYM    = 8'hBC
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       init,
  input  logic       fifo0_empty,
  input  logic       fifo1_empty,
  input  logic [7:0] fifo0_data,
  input  logic [7:0] fifo1_data,
  input  logic       down_almost_full,
  output logic       pop0,
  output logic       pop1,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       lane_out,
  output logic       active_out,
  output logic       idle_out
);

  localparam logic [1:0] ST_RESET  = 2'd0;
  localparam logic [1:0] ST_INIT   = 2'd1;
  localparam logic [1:0] ST_IDLE   = 2'd2;
  localparam logic [1:0] ST_ACTIVE = 2'd3;

`ifdef IDLE_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  localparam logic [7:0] DATA_RST = FILL_EN ? IDLE_SYM : 8'h00;
  localparam logic [3:0] CNT_LAST = 4'(INIT_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_grant_q, last_grant_d;
  logic       pending_q, pending_d;
  logic       pend_lane_q, pend_lane_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       lane_q, lane_d;
  logic       any_ready;
  logic       pop_en;
  logic       grant;

  always_comb begin
    any_ready = !fifo0_empty || !fifo1_empty;
    // A restart request launches no new pop; the word already in flight still drains.
    pop_en    = (state_q == ST_ACTIVE) && !down_almost_full && !init && any_ready;
    if (!fifo0_empty && !fifo1_empty) grant = !last_grant_q;
    else                              grant = fifo0_empty;
    pop0 = pop_en && !grant;
    pop1 = pop_en && grant;

    last_grant_d = pop_en ? grant : last_grant_q;
    pend_lane_d  = pop_en ? grant : pend_lane_q;
    pending_d    = pop_en;

    // Word returned by the FIFO this cycle is registered at the edge.
    valid_d = pending_q;
    lane_d  = pending_q ? pend_lane_q : lane_q;
    if (pending_q)    data_d = pend_lane_q ? fifo1_data : fifo0_data;
    else if (FILL_EN) data_d = IDLE_SYM;
    else              data_d = data_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
      ST_INIT: begin
        if (cnt_q == CNT_LAST) state_d = ST_IDLE;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      ST_IDLE: begin
        if (init) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (any_ready && !down_almost_full) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (init) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (!any_ready && !pending_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      pending_q    <= 1'b0;
      pend_lane_q  <= 1'b0;
      data_q       <= DATA_RST;
      valid_q      <= 1'b0;
      lane_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      pend_lane_q  <= pend_lane_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      lane_q       <= lane_d;
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign lane_out   = lane_q;
  assign active_out = (state_q == ST_ACTIVE);
  assign idle_out   = (state_q == ST_IDLE);

endmodule
